// File: rtl/aes_round_scheduler_if.sv
// Handshake and status bundle between the AES round-loop controller and its environment.
interface aes_round_scheduler_if #(
    parameter int unsigned TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             sel_new;
    logic             issue_valid;
    logic [7:0]       issue_rcon;
    logic             issue_final;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_tag;
    logic [4:0]       occupancy;
    logic [15:0]      blocks_done;

    // Environment side: drives flush/in_valid, observes everything else.
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        input  sel_new,
        input  issue_valid,
        input  issue_rcon,
        input  issue_final,
        input  retire_valid,
        input  retire_tag,
        input  occupancy,
        input  blocks_done
    );

    // Scheduler side.
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        output sel_new,
        output issue_valid,
        output issue_rcon,
        output issue_final,
        output retire_valid,
        output retire_tag,
        output occupancy,
        output blocks_done
    );
endinterface

// File: rtl/aes_round_scheduler.sv
// Slot/round bookkeeping for the looped AES round pipeline: a shift ring mirrors the
// datapath loop, the tail decides recirculate / retire / admit each cycle.
module aes_round_scheduler #(
    parameter int unsigned LOOP_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input logic                  clock,
    input logic                  reset,
    aes_round_scheduler_if.slave bus
);

    if (LOOP_DEPTH < 2 || LOOP_DEPTH > 16) begin : g_bad_depth
        $error("aes_round_scheduler: LOOP_DEPTH must be in 2..16");
    end
    if (LOOP_DEPTH > (32'd1 << TAG_W)) begin : g_bad_tag
        $error("aes_round_scheduler: TAG_W too narrow for unique tags in flight");
    end

    localparam int unsigned Tail = LOOP_DEPTH - 1;

    typedef struct packed {
        logic             valid;
        logic [7:0]       rcon;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    entry_t [LOOP_DEPTH-1:0] ring_q, ring_d;
    logic [TAG_W-1:0]        next_tag_q, next_tag_d;
    logic                    sel_new_q, sel_new_d;
    logic                    issue_final_q, issue_final_d;
    logic                    retire_valid_q, retire_valid_d;
    logic [TAG_W-1:0]        retire_tag_q, retire_tag_d;
    logic [4:0]              occupancy_q, occupancy_d;
    logic [15:0]             blocks_done_q, blocks_done_d;

    entry_t tail;
    logic   tail_final;
    logic   recirc;
    logic   retire;
    logic   admit;

    // Tail decode: a live non-final block always owns the entry mux.
    always_comb begin
        tail       = ring_q[Tail];
        tail_final = (tail.rcon == 8'h36);
        recirc     = tail.valid && !tail_final;
        retire     = tail.valid && tail_final && !bus.flush;
        admit      = !recirc && !bus.flush && bus.in_valid;
    end

    assign bus.in_ready     = !recirc && !bus.flush;
    assign bus.sel_new      = sel_new_q;
    assign bus.issue_valid  = ring_q[0].valid;
    assign bus.issue_rcon   = ring_q[0].rcon;
    assign bus.issue_final  = issue_final_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_tag   = retire_tag_q;
    assign bus.occupancy    = occupancy_q;
    assign bus.blocks_done  = blocks_done_q;

    // Next-state: shift the ring, fill entry 0 from the tail or the input, count blocks.
    always_comb begin
        ring_d = ring_q;
        for (int k = 1; k < LOOP_DEPTH; k++) begin
            ring_d[k] = ring_q[k-1];
        end
        ring_d[0]      = '0;
        next_tag_d     = next_tag_q;
        sel_new_d      = 1'b0;
        retire_valid_d = 1'b0;
        retire_tag_d   = retire_tag_q;
        occupancy_d    = occupancy_q;
        blocks_done_d  = blocks_done_q;

        if (bus.flush) begin
            ring_d      = '0;
            occupancy_d = '0;
        end else begin
            if (recirc) begin
                ring_d[0] = {1'b1, xtime(tail.rcon), tail.tag};
            end else if (admit) begin
                ring_d[0]  = {1'b1, 8'h01, next_tag_q};
                next_tag_d = next_tag_q + 1'b1;
                sel_new_d  = 1'b1;
            end
            if (retire) begin
                retire_valid_d = 1'b1;
                retire_tag_d   = tail.tag;
                blocks_done_d  = blocks_done_q + 16'd1;
            end
            // Admit and retire in the same cycle reuse the slot; count is unchanged.
            case ({admit, retire})
                2'b10:   occupancy_d = occupancy_q + 5'd1;
                2'b01:   occupancy_d = occupancy_q - 5'd1;
                default: occupancy_d = occupancy_q;
            endcase
        end

        issue_final_d = ring_d[0].valid && (ring_d[0].rcon == 8'h36);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ring_q         <= '0;
            next_tag_q     <= '0;
            sel_new_q      <= 1'b0;
            issue_final_q  <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
            occupancy_q    <= '0;
            blocks_done_q  <= '0;
        end else begin
            ring_q         <= ring_d;
            next_tag_q     <= next_tag_d;
            sel_new_q      <= sel_new_d;
            issue_final_q  <= issue_final_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
            occupancy_q    <= occupancy_d;
            blocks_done_q  <= blocks_done_d;
        end
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed, table-driven bench for aes_round_scheduler with LOOP_DEPTH=4, TAG_W=4.
module tb_aes_round_scheduler;
    localparam int unsigned LD = 4;
    localparam int unsigned TW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    aes_round_scheduler_if #(.TAG_W(TW)) bus ();

    aes_round_scheduler #(
        .LOOP_DEPTH(LD),
        .TAG_W     (TW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        logic        iv;
        logic [7:0]  rcon;
        logic        fin;
        logic        sel;
        logic        rv;
        logic [4:0]  occ;
        logic [15:0] done;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int k;
        int nz;
        int n;
        int rv_seen;
        int mx;
        logic [TW-1:0] et;

        // Single-block expectations: k = edges after admission edge.
        tbl[0]  = '{0,  1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 5'd1, 16'd0};
        tbl[1]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[2]  = '{4,  1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[3]  = '{8,  1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[4]  = '{12, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[5]  = '{16, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[6]  = '{20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[7]  = '{24, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[8]  = '{28, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[9]  = '{32, 1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[10] = '{36, 1'b1, 8'h36, 1'b1, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[11] = '{37, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[12] = '{39, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 16'd0};
        tbl[13] = '{40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 16'd1};
        tbl[14] = '{41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 16'd1};

        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        do_reset();

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_issue_rcon", 32'(bus.issue_rcon), 32'd0);
        chk("rst_sel_new", 32'(bus.sel_new), 32'd0);
        chk("rst_retire_valid", 32'(bus.retire_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_blocks_done", 32'(bus.blocks_done), 32'd0);

        // Single block through all ten rounds
        bus.in_valid = 1'b1;
        #1 chk("single_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            while (k < tbl[i].k) begin
                tick();
                k++;
            end
            chk($sformatf("single_k%0d_valid", k), 32'(bus.issue_valid), 32'(tbl[i].iv));
            chk($sformatf("single_k%0d_rcon", k), 32'(bus.issue_rcon), 32'(tbl[i].rcon));
            chk($sformatf("single_k%0d_final", k), 32'(bus.issue_final), 32'(tbl[i].fin));
            chk($sformatf("single_k%0d_sel", k), 32'(bus.sel_new), 32'(tbl[i].sel));
            chk($sformatf("single_k%0d_retire", k), 32'(bus.retire_valid), 32'(tbl[i].rv));
            chk($sformatf("single_k%0d_occ", k), 32'(bus.occupancy), 32'(tbl[i].occ));
            chk($sformatf("single_k%0d_done", k), 32'(bus.blocks_done), 32'(tbl[i].done));
            if (tbl[i].rv) chk("single_retire_tag", 32'(bus.retire_tag), 32'd0);
        end

        // Full loop with in_valid held high
        do_reset();
        bus.in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk($sformatf("full_admit%0d_ready", j), 32'(bus.in_ready), 32'd1);
            tick();
        end
        chk("full_occ4", 32'(bus.occupancy), 32'd4);
        nz = 0;
        for (int j = 0; j < 36; j++) begin
            #1;
            if (bus.in_ready === 1'b0) nz++;
            tick();
        end
        chk("full_stall_cycles", 32'(nz), 32'd36);
        #1 chk("full_ready_at_retire", 32'(bus.in_ready), 32'd1);
        tick();
        chk("full_retire_valid", 32'(bus.retire_valid), 32'd1);
        chk("full_retire_tag0", 32'(bus.retire_tag), 32'd0);
        chk("full_occ_kept", 32'(bus.occupancy), 32'd4);
        chk("full_sel_new", 32'(bus.sel_new), 32'd1);
        chk("full_new_rcon", 32'(bus.issue_rcon), 32'h01);
        tick();
        chk("full_retire_tag1", 32'(bus.retire_tag), 32'd1);
        chk("full_retire_valid1", 32'(bus.retire_valid), 32'd1);
        bus.in_valid = 1'b0;

        // Back-pressure: tail holds rcon 02 while in_valid is high
        do_reset();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        bus.in_valid = 1'b1;
        #1 chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_sel_new", 32'(bus.sel_new), 32'd0);
        chk("bp_rcon", 32'(bus.issue_rcon), 32'h04);
        chk("bp_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("bp_occ", 32'(bus.occupancy), 32'd1);

        // Flush with three blocks in round 5
        do_reset();
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        repeat (17) tick();
        chk("flush_pre_occ", 32'(bus.occupancy), 32'd3);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1 chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_occ", 32'(bus.occupancy), 32'd0);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        rv_seen = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (bus.retire_valid !== 1'b0) rv_seen++;
        end
        chk("flush_no_retire", 32'(rv_seen), 32'd0);
        bus.in_valid = 1'b1;
        #1 chk("flush_readmit_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("flush_readmit_rcon", 32'(bus.issue_rcon), 32'h01);
        repeat (40) tick();
        chk("flush_readmit_retire", 32'(bus.retire_valid), 32'd1);
        chk("flush_readmit_tag3", 32'(bus.retire_tag), 32'd3);
        chk("flush_readmit_done", 32'(bus.blocks_done), 32'd1);

        // Asynchronous reset between edges with two blocks in flight
        bus.in_valid = 1'b1;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("areset_pre_occ", 32'(bus.occupancy), 32'd2);
        #3 reset = 1'b1;
        #1;
        chk("areset_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("areset_issue_rcon", 32'(bus.issue_rcon), 32'd0);
        chk("areset_final", 32'(bus.issue_final), 32'd0);
        chk("areset_sel", 32'(bus.sel_new), 32'd0);
        chk("areset_occ", 32'(bus.occupancy), 32'd0);
        chk("areset_done", 32'(bus.blocks_done), 32'd0);
        chk("areset_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        reset = 1'b0;
        rv_seen = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (bus.retire_valid !== 1'b0) rv_seen++;
        end
        chk("areset_no_retire", 32'(rv_seen), 32'd0);

        // Counter wrap and tag wrap over 17 retirements
        do_reset();
        force dut.blocks_done_q = 16'hFFFF;
        #1 release dut.blocks_done_q;
        #1 chk("wrap_preload", 32'(bus.blocks_done), 32'hFFFF);
        bus.in_valid = 1'b1;
        n  = 0;
        mx = 0;
        et = '0;
        for (int c = 0; c < 400 && n < 17; c++) begin
            tick();
            if (int'(bus.occupancy) > mx) mx = int'(bus.occupancy);
            if (bus.retire_valid === 1'b1) begin
                chk($sformatf("wrap_tag_n%0d", n), 32'(bus.retire_tag), 32'(et));
                if (n == 0) chk("wrap_done_zero", 32'(bus.blocks_done), 32'd0);
                et = et + 1'b1;
                n++;
            end
        end
        bus.in_valid = 1'b0;
        chk("wrap_retire_count", 32'(n), 32'd17);
        chk("wrap_done_final", 32'(bus.blocks_done), 32'd16);
        chk("wrap_max_occ", 32'(mx), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
